// File: rtl/cpu_pkg.sv
// Pipeline-wide constants and types shared by the fetch stage and the later stages
// (bubble encoding, PC arithmetic).
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] npc;
  } fetch_word_t;

  localparam fetch_word_t BUBBLE_WORD = '{instr: NOP_INSTR, npc: '0};

  // Per-cycle action, in decreasing priority order.
  typedef enum logic [1:0] {
    ModeReset,
    ModeBranch,
    ModeFreeze,
    ModeRun
  } fetch_mode_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry capture buffer: parks the word returned by imem while the pipe is frozen.
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  fetch_word_t word_in,
  output fetch_word_t word,
  output logic        valid
);

  fetch_word_t word_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q  <= BUBBLE_WORD;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= word_in;
      valid_q <= 1'b1;
    end
  end

  assign word  = word_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// presents {instruction, next_pc, valid} to decode, honouring freeze and branch redirect.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] next_pc,
  output logic            valid
);

  fetch_mode_e     mode;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;
  fetch_word_t     out_q, out_d;
  logic            out_valid_q, out_valid_d;

  fetch_word_t     ret_word;
  fetch_word_t     hold_word;
  logic            hold_valid;
  logic            hold_load;
  logic            hold_clear;

  always_comb begin
    if (rst)               mode = ModeReset;
    else if (branch_taken) mode = ModeBranch;
    else if (freeze)       mode = ModeFreeze;
    else                   mode = ModeRun;
  end

  // Address path depends only on control inputs and pc, never on imem_rdata.
  always_comb begin
    imem_en   = 1'b0;
    imem_addr = pc_q;
    unique case (mode)
      ModeBranch: begin
        imem_en   = 1'b1;
        imem_addr = word_align(branch_addr);
      end
      ModeRun:    imem_en = 1'b1;
      default:    ;
    endcase
  end

  // Word returning this cycle for the fetch issued last cycle.
  assign ret_word = '{instr: imem_rdata, npc: req_pc_q + PC_STEP};

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    unique case (mode)
      ModeReset: begin
        pc_d        = RESET_PC;
        req_valid_d = 1'b0;
        out_d       = BUBBLE_WORD;
        out_valid_d = 1'b0;
      end
      ModeBranch: begin
        req_pc_d    = imem_addr;
        req_valid_d = 1'b1;
        pc_d        = imem_addr + PC_STEP;
        hold_clear  = 1'b1;
        out_d       = BUBBLE_WORD;
        out_valid_d = 1'b0;
      end
      ModeFreeze: begin
        hold_load   = req_valid_q;
        req_valid_d = 1'b0;
      end
      ModeRun: begin
        hold_clear = 1'b1;
        if (hold_valid) begin
          out_d       = hold_word;
          out_valid_d = 1'b1;
        end else if (req_valid_q) begin
          out_d       = ret_word;
          out_valid_d = 1'b1;
        end else begin
          out_d       = BUBBLE_WORD;
          out_valid_d = 1'b0;
        end
        req_pc_d    = pc_q;
        req_valid_d = 1'b1;
        pc_d        = pc_q + PC_STEP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      out_q       <= BUBBLE_WORD;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (hold_clear),
    .load    (hold_load),
    .word_in (ret_word),
    .word    (hold_word),
    .valid   (hold_valid)
  );

  assign instruction = out_q.instr;
  assign next_pc     = out_q.npc;
  assign valid       = out_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: a queue-based model of issued-but-undelivered addresses
// predicts every output; a monitor compares after each rising edge.
module tb_if_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr;
  logic        imem_en;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instruction, next_pc;
  logic        valid;

  always #5 clk = ~clk;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .next_pc      (next_pc),
    .valid        (valid)
  );

  // Synchronous memory; content is the address xor a salt, garbage when not read.
  logic [31:0] salt = 32'h0;
  always @(posedge clk) imem_rdata <= imem_en ? (imem_addr ^ salt) : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        v;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference model: addresses issued but not yet delivered, next address to issue.
  logic [31:0] m_flight[$];
  logic [31:0] m_next = 32'h0;
  exp_t        m_out  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle: set inputs, check the combinational imem request, advance the model.
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    logic [31:0] a;
    rst          = r;
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    #1;
    if (r) begin
      check("imem_en_rst", {31'b0, imem_en}, 32'd0);
    end else if (b) begin
      check("imem_en_branch", {31'b0, imem_en}, 32'd1);
      check("imem_addr_branch", imem_addr, {ba[31:2], 2'b00});
    end else if (f) begin
      check("imem_en_freeze", {31'b0, imem_en}, 32'd0);
    end else begin
      check("imem_en_run", {31'b0, imem_en}, 32'd1);
      check("imem_addr_run", imem_addr, m_next);
    end

    if (r) begin
      m_flight.delete();
      m_next = 32'h0;
      m_out  = '0;
    end else if (b) begin
      m_flight.delete();
      a = {ba[31:2], 2'b00};
      m_flight.push_back(a);
      m_next = a + 32'd4;
      m_out  = '0;
    end else if (!f) begin
      if (m_flight.size() > 0) begin
        a     = m_flight.pop_front();
        m_out = '{instr: a ^ salt, npc: a + 32'd4, v: 1'b1};
      end else begin
        m_out = '0;
      end
      m_flight.push_back(m_next);
      m_next = m_next + 32'd4;
    end
    exp_q.push_back(m_out);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid", {31'b0, valid}, {31'b0, e.v});
        check("instruction", instruction, e.instr);
        check("next_pc", next_pc, e.npc);
      end
    end
  end

  initial begin : driver
    logic r, f, b;
    logic [31:0] ba;
    // Reset, then sequential stream from address 0.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(4);
    // Three-cycle freeze with a fetch in flight.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    run(3);
    // Redirect to an unaligned target.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    run(4);
    // Fill the hold buffer, then branch and freeze together.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    run(3);
    // PC wrap-around.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(4);
    // Reset while the hold buffer is full.
    run(2);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    run(4);
    // Reset in the middle of a redirect.
    step(1'b0, 1'b0, 1'b1, 32'h0000_2000);
    step(1'b1, 1'b0, 1'b1, 32'h0000_3000);
    run(3);

    // Random traffic with a non-trivial memory pattern.
    salt = $urandom;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(99) < 2);
      b  = ($urandom_range(99) < 12);
      f  = ($urandom_range(99) < 30);
      ba = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(r, f, b, ba);
    end
    run(2);

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
